mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 32, RAM depth in 32-bit words; AW = clog2(DEPTH) (5 at default).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_valid/cpu_instr  input  1/1  CPU native-bus request and instruction-fetch tag; cpu_addr, cpu_wdata  input  32  address, write data; cpu_wstrb  input  4  byte write enables (0 = read).
REQ-005 cpu_ready  output  1  one-cycle completion pulse; cpu_rdata  output  32  read data, valid while cpu_ready=1.
REQ-006 dbg_valid, dbg_addr[31:0], dbg_wdata[31:0], dbg_wstrb[3:0] input; dbg_ready, dbg_rdata[31:0] output: second requester (loader/debug), same protocol.
REQ-007 ram_addr  output  AW  word address (byte address bits [AW+1:2]); ram_din  output  32; ram_we  output  4  byte write mask; ram_dout  input  32, synchronous read, valid the cycle after ram_addr.
REQ-008 err_clr  input  1  clears err; err  output  1  sticky out-of-range flag; grant_dbg  output  1  high while dbg owns the in-flight access.

Function
REQ-009 Protocol: requester holds valid and request fields until its ready pulse; arbiter never asserts ready without an accepted request.
REQ-010 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE when any valid=1; ISSUE->RESP always; RESP->IDLE always.
REQ-011 In IDLE, winning request's addr/wdata/wstrb/requester id are latched at the clock edge.
REQ-012 Arbitration: single requester wins; both valid -> requester not granted last wins (round-robin); last-grant initialised to dbg so CPU wins the first tie.
REQ-013 ISSUE: ram_addr = latched addr[AW+1:2], ram_din = latched wdata, ram_we = latched wstrb, for exactly one cycle; ram_we = 0 in all other states.
REQ-014 RESP: granted requester's ready = 1 for one cycle; its rdata = ram_dout for reads (wstrb=0), 0 for writes; non-granted ready = 0, rdata = 0.
REQ-015 Latency: valid sampled at edge N -> ready high in cycle N+2; max throughput one access per 3 cycles.
REQ-016 Out-of-range: latched addr[31:AW+2] != 0 -> ram_we forced 0, rdata = 0, ready still pulses, err set at RESP.
REQ-017 addr[1:0] ignored (no misalign trap); cpu_instr does not affect arbitration or data.
REQ-018 valid deasserted mid-transaction: transaction completes, ready still pulses.
REQ-019 err_clr and a new error in the same cycle: err stays 1 (set wins).
REQ-020 Valid held high in IDLE after own RESP is a new request, arbitrated normally.

Reset
REQ-021 reset asserted: state=IDLE, last-grant=dbg, err=0, latched fields=0, immediately (asynchronously).
REQ-022 During reset: cpu_ready=dbg_ready=0, ram_we=0, ram_addr=0, ram_din=0, rdata outputs=0, grant_dbg=0.
REQ-023 Reset mid-transaction aborts it: no ready pulse and no RAM write after reset asserts.

Structure
REQ-024 Shared package mem_arb_pkg holds the state enum (IDLE/ISSUE/RESP), the requester id enum (REQ_CPU/REQ_DBG), and the DEPTH default constant.
REQ-025 One sub-module rr_arb2 (2-way round-robin, last-grant register, grant output) is instantiated; the FSM and datapath stay in mem_port_arbiter.

Verification
REQ-026 CPU read addr 0x0000_0008 with RAM word 2 = 0xDEAD_BEEF -> ram_addr=2 at N+1, cpu_ready=1 and cpu_rdata=0xDEADBEEF at N+2, dbg_ready=0.
REQ-027 dbg write addr 0x0C, wdata 0x1234_5678, wstrb 0x3 -> ram_we=0x3, ram_addr=3 for one cycle; dbg_ready at N+2 with dbg_rdata=0.
REQ-028 Both valid from reset, held -> grants CPU, dbg, CPU, dbg; readies 3 cycles apart; grant_dbg alternates.
REQ-029 CPU write addr 0x0000_0100 (DEPTH=32) -> ram_we stays 0, cpu_ready pulses, err=1; err_clr -> err=0; err_clr with a new error the same cycle -> err=1.
REQ-030 reset asserted during ISSUE of a write -> ram_we=0 immediately, no ready pulse, next request after release granted to CPU on a tie.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter
package mem_arb_pkg;
  localparam int DEPTH_DEFAULT = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic {REQ_CPU, REQ_DBG} req_id_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, ties go to the requester not granted last
module rr_arb2 import mem_arb_pkg::*; (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_cpu,
  input  logic    i_dbg,
  input  logic    i_take,
  output req_id_e o_grant
);
  req_id_e r_last;
  assign o_grant = (i_cpu && i_dbg) ? ((r_last == REQ_DBG) ? REQ_CPU : REQ_DBG)
                                    : (i_dbg ? REQ_DBG : REQ_CPU);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_last <= REQ_DBG;
    else if (i_take) r_last <= o_grant;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous RAM port between a CPU bus and a debug/loader bus
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_valid,
  input  logic          cpu_instr,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [3:0]    cpu_wstrb,
  output logic          cpu_ready,
  output logic [31:0]   cpu_rdata,
  input  logic          dbg_valid,
  input  logic [31:0]   dbg_addr,
  input  logic [31:0]   dbg_wdata,
  input  logic [3:0]    dbg_wstrb,
  output logic          dbg_ready,
  output logic [31:0]   dbg_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  output logic [3:0]    ram_we,
  input  logic [31:0]   ram_dout,
  input  logic          err_clr,
  output logic          err,
  output logic          grant_dbg
);
  state_e      r_state, w_next;
  req_id_e     r_id, w_grant;
  logic [31:0] r_addr, r_wdata, w_rdata;
  logic [3:0]  r_wstrb;
  logic        r_err, w_any, w_take, w_oor, w_resp, w_unused;
  assign w_any  = cpu_valid | dbg_valid;
  assign w_take = (r_state == IDLE) && w_any;
  assign w_oor  = |r_addr[31:AW+2];
  assign w_unused = &{1'b0, cpu_instr, r_addr[1:0]};
  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_cpu   (cpu_valid),
    .i_dbg   (dbg_valid),
    .i_take  (w_take),
    .o_grant (w_grant)
  );
  always_comb begin
    w_next = (r_state == IDLE) ? (w_any ? ISSUE : IDLE) : (r_state == ISSUE) ? RESP : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_id    <= REQ_CPU;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_id    <= w_grant;
        r_addr  <= (w_grant == REQ_DBG) ? dbg_addr  : cpu_addr;
        r_wdata <= (w_grant == REQ_DBG) ? dbg_wdata : cpu_wdata;
        r_wstrb <= (w_grant == REQ_DBG) ? dbg_wstrb : cpu_wstrb;
      end
      // a new error outranks a simultaneous clear
      r_err <= ((r_state == ISSUE) && w_oor) | (r_err & ~err_clr);
    end
  assign ram_addr  = r_addr[AW+1:2];
  assign ram_din   = r_wdata;
  assign ram_we    = ((r_state == ISSUE) && !w_oor) ? r_wstrb : 4'h0;
  assign w_resp    = (r_state == RESP);
  assign w_rdata   = ((r_wstrb == 4'h0) && !w_oor) ? ram_dout : 32'h0;
  assign cpu_ready = w_resp && (r_id == REQ_CPU);
  assign dbg_ready = w_resp && (r_id == REQ_DBG);
  assign cpu_rdata = cpu_ready ? w_rdata : 32'h0;
  assign dbg_rdata = dbg_ready ? w_rdata : 32'h0;
  assign grant_dbg = (r_state != IDLE) && (r_id == REQ_DBG);
  assign err       = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the arbiter against a behavioural RAM
module tb_mem_port_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_valid = 0, cpu_instr = 0, dbg_valid = 0, err_clr = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
  logic [3:0]  cpu_wstrb = 0, dbg_wstrb = 0;
  logic        cpu_ready, dbg_ready, err, grant_dbg;
  logic [31:0] cpu_rdata, dbg_rdata, ram_din, ram_dout;
  logic [4:0]  ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] mem [32];
  int checks = 0, errors = 0;
  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_wstrb(dbg_wstrb), .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .err_clr(err_clr), .err(err), .grant_dbg(grant_dbg)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[2] = 32'hDEAD_BEEF;
    #1;
    chk("rst_ready", {30'h0, cpu_ready, dbg_ready}, 32'h0);
    chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
    chk("rst_ram_addr", {27'h0, ram_addr}, 32'h0);
    chk("rst_ram_din", ram_din, 32'h0);
    chk("rst_flags", {30'h0, grant_dbg, err}, 32'h0);
    chk("rst_rdata", cpu_rdata | dbg_rdata, 32'h0);
    step; reset = 1'b0;
    // CPU read of word 2
    cpu_valid = 1; cpu_instr = 1; cpu_addr = 32'h8; cpu_wstrb = 0;
    step;
    chk("rd_ram_addr", {27'h0, ram_addr}, 32'd2);
    chk("rd_ram_we", {28'h0, ram_we}, 32'h0);
    chk("rd_early_ready", {31'h0, cpu_ready}, 32'h0);
    step;
    chk("rd_ready", {30'h0, cpu_ready, dbg_ready}, 32'h2);
    chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_valid = 0; cpu_instr = 0;
    step;
    // dbg partial write of word 3
    dbg_valid = 1; dbg_addr = 32'hC; dbg_wdata = 32'h1234_5678; dbg_wstrb = 4'h3;
    step;
    chk("wr_ram_we", {28'h0, ram_we}, 32'h3);
    chk("wr_ram_addr", {27'h0, ram_addr}, 32'd3);
    chk("wr_ram_din", ram_din, 32'h1234_5678);
    chk("wr_grant_dbg", {31'h0, grant_dbg}, 32'h1);
    step;
    chk("wr_ram_we_off", {28'h0, ram_we}, 32'h0);
    chk("wr_ready", {30'h0, cpu_ready, dbg_ready}, 32'h1);
    chk("wr_rdata", dbg_rdata, 32'h0);
    chk("wr_mem3", mem[3], 32'h0000_5678);
    dbg_valid = 0; dbg_wstrb = 0;
    step;
    // round robin from reset, both held
    reset = 1; step; reset = 0;
    cpu_valid = 1; cpu_addr = 32'h8; cpu_wstrb = 0;
    dbg_valid = 1; dbg_addr = 32'hC; dbg_wstrb = 0;
    for (int i = 1; i <= 11; i++) begin
      logic [2:0] e;
      step;
      e = {i == 2 || i == 8, i == 5 || i == 11, i == 4 || i == 5 || i == 10 || i == 11};
      chk($sformatf("rr_cyc%0d", i), {29'h0, cpu_ready, dbg_ready, grant_dbg}, {29'h0, e});
      if (e[2]) chk($sformatf("rr_cpu_rdata%0d", i), cpu_rdata, 32'hDEAD_BEEF);
      if (e[1]) chk($sformatf("rr_dbg_rdata%0d", i), dbg_rdata, 32'h0000_5678);
    end
    cpu_valid = 0; dbg_valid = 0;
    step;
    // out-of-range write, then sticky error handling
    cpu_valid = 1; cpu_addr = 32'h100; cpu_wdata = 32'hFFFF_FFFF; cpu_wstrb = 4'hF;
    step;
    chk("oor_ram_we", {28'h0, ram_we}, 32'h0);
    chk("oor_err_pre", {31'h0, err}, 32'h0);
    step;
    chk("oor_ready", {30'h0, cpu_ready, dbg_ready}, 32'h2);
    chk("oor_rdata", cpu_rdata, 32'h0);
    chk("oor_err", {31'h0, err}, 32'h1);
    cpu_valid = 0;
    step;
    chk("oor_err_sticky", {31'h0, err}, 32'h1);
    err_clr = 1;
    step;
    chk("oor_err_clr", {31'h0, err}, 32'h0);
    err_clr = 0; cpu_valid = 1;
    step;
    err_clr = 1;
    step;
    chk("oor_set_wins", {31'h0, err}, 32'h1);
    chk("oor_mem0", mem[0], 32'h0);
    cpu_valid = 0; err_clr = 0;
    step;
    // reset during ISSUE of a write
    cpu_valid = 1; cpu_addr = 32'h10; cpu_wdata = 32'hAAAA_5555; cpu_wstrb = 4'hF;
    step;
    chk("ab_ram_we", {28'h0, ram_we}, 32'hF);
    #1 reset = 1;
    #1;
    chk("ab_ram_we_off", {28'h0, ram_we}, 32'h0);
    chk("ab_ram_addr", {27'h0, ram_addr}, 32'h0);
    chk("ab_ram_din", ram_din, 32'h0);
    chk("ab_flags", {29'h0, cpu_ready, dbg_ready, grant_dbg}, 32'h0);
    cpu_valid = 0; cpu_wstrb = 0;
    step;
    chk("ab_no_ready", {30'h0, cpu_ready, dbg_ready}, 32'h0);
    chk("ab_mem4", mem[4], 32'h0);
    reset = 0;
    cpu_valid = 1; cpu_addr = 32'h8; dbg_valid = 1; dbg_addr = 32'hC; dbg_wstrb = 0;
    step;
    chk("ab_tie_grant", {31'h0, grant_dbg}, 32'h0);
    chk("ab_tie_addr", {27'h0, ram_addr}, 32'd2);
    step;
    chk("ab_tie_ready", {30'h0, cpu_ready, dbg_ready}, 32'h2);
    cpu_valid = 0; dbg_valid = 0;
    step;
    // valid dropped mid-transaction still completes
    dbg_valid = 1; dbg_addr = 32'h8;
    step;
    dbg_valid = 0;
    step;
    chk("drop_ready", {30'h0, cpu_ready, dbg_ready}, 32'h1);
    chk("drop_rdata", dbg_rdata, 32'hDEAD_BEEF);
    step;
    chk("drop_idle", {30'h0, cpu_ready, dbg_ready}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
